// File: rtl/lcd_responder_if.sv
// Bus between an HD44780-style controller and lcd_responder: strobed write/read
// transfers plus the responder's read-back and busy flag.
interface lcd_responder_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  modport master (
    output LCD_DATA, LCD_RS, LCD_RW, LCD_EN,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/lcd_responder.sv
// Behavioural 2x16 character-LCD responder: decodes EN-strobed transfers, keeps DDRAM and AC.
// Optional EN pulse-width checking is built when LCD_RESP_TIMING_CHECK_EN is defined.
module lcd_responder #(
  parameter int unsigned BUSY_CYCLES  = 40,
  parameter int unsigned CLEAR_CYCLES = 1600,
  parameter int unsigned MIN_EN_HIGH  = 10
) (
  input  logic                  clk2,
  input  logic                  rst,
  lcd_responder_if.slave        bus,
  output logic                  disp_on,
  input  logic [4:0]            char_idx,
  output logic [7:0]            char_out,
  output logic                  proto_err,
  output logic                  timing_err
);

  localparam int unsigned CntMax = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1) + 1;
  localparam logic [CntW-1:0] BusyLoad  = (BUSY_CYCLES == 0)  ? '0 : CntW'(BUSY_CYCLES - 1);
  localparam logic [CntW-1:0] ClearLoad = (CLEAR_CYCLES == 0) ? '0 : CntW'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            long_q, long_d;

  logic       en_q, rs_q, rw_q;
  logic [7:0] data_q;
  logic       fall, width_ok, commit_q;

  logic [6:0] ac_q, ac_d;
  logic       id_q, id_d;
  logic       disp_q, disp_d;
  logic [7:0] cells_q [32];
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       perr_q, perr_d;

  logic       busy_now, ac_ok, wr_en, clr_all, start_exec, start_long;
  logic [4:0] cell_idx;

  // Next AC for a legal address; the two display lines are stitched into one 32-cell ring.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      unique case (ac)
        7'h0F:   nxt = 7'h40;
        7'h4F:   nxt = 7'h00;
        default: nxt = ac + 7'd1;
      endcase
    end else begin
      unique case (ac)
        7'h00:   nxt = 7'h4F;
        7'h40:   nxt = 7'h0F;
        default: nxt = ac - 7'd1;
      endcase
    end
    return nxt;
  endfunction

  assign fall     = en_q & ~bus.LCD_EN;
  assign busy_now = (state_q != StIdle);
  assign ac_ok    = (ac_q[5:4] == 2'b00);
  assign cell_idx = {ac_q[6], ac_q[3:0]};

`ifdef LCD_RESP_TIMING_CHECK_EN
  localparam int unsigned EnCntW = $clog2(MIN_EN_HIGH + 1) + 1;
  logic [EnCntW-1:0] en_cnt_q;
  logic              terr_q;

  assign width_ok   = (en_cnt_q >= EnCntW'(MIN_EN_HIGH));
  assign timing_err = terr_q;

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      en_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      if (!bus.LCD_EN) begin
        en_cnt_q <= '0;
      end else if (en_cnt_q < EnCntW'(MIN_EN_HIGH)) begin
        en_cnt_q <= en_cnt_q + 1'b1;
      end
      if (fall && !width_ok) begin
        terr_q <= 1'b1;
      end
    end
  end
`else
  // Only the width check consumes this parameter.
  logic unused_min_en_high;
  assign unused_min_en_high = ^MIN_EN_HIGH;
  assign width_ok   = 1'b1;
  assign timing_err = 1'b0;
`endif

  // Transfer decode, evaluated in the commit cycle.
  always_comb begin
    ac_d       = ac_q;
    id_d       = id_q;
    disp_d     = disp_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    perr_d     = perr_q;
    wr_en      = 1'b0;
    clr_all    = 1'b0;
    start_exec = 1'b0;
    start_long = 1'b0;
    if (commit_q) begin
      if (rw_q) begin
        if (!rs_q) begin
          rd_data_d  = {busy_now, ac_q};
          rd_valid_d = 1'b1;
        end else if (ac_ok) begin
          rd_data_d  = cells_q[cell_idx];
          rd_valid_d = 1'b1;
          ac_d       = ac_step(ac_q, id_q);
        end else begin
          perr_d = 1'b1;
        end
      end else if (busy_now) begin
        perr_d = 1'b1;
      end else if (rs_q) begin
        if (ac_ok) begin
          wr_en      = 1'b1;
          ac_d       = ac_step(ac_q, id_q);
          start_exec = 1'b1;
        end else begin
          perr_d = 1'b1;
        end
      end else begin
        start_exec = 1'b1;
        priority casez (data_q)
          8'b1???????: ac_d = data_q[6:0];
          8'b01??????,
          8'b001?????,
          8'b0001????: ;
          8'b00001???: disp_d = data_q[2];
          8'b000001??: id_d = data_q[1];
          8'b0000001?: begin
            ac_d       = '0;
            start_long = 1'b1;
          end
          8'b00000001: begin
            clr_all    = 1'b1;
            ac_d       = '0;
            id_d       = 1'b1;
            start_long = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    unique case (state_q)
      StIdle: begin
        if (start_exec) begin
          state_d = StExec;
          long_d  = start_long;
        end
      end
      StExec: begin
        state_d = StBusy;
        cnt_d   = long_q ? ClearLoad : BusyLoad;
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      en_q       <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      data_q     <= '0;
      commit_q   <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      long_q     <= 1'b0;
      ac_q       <= '0;
      id_q       <= 1'b1;
      disp_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      for (int i = 0; i < 32; i++) cells_q[i] <= 8'h20;
    end else begin
      en_q <= bus.LCD_EN;
      if (bus.LCD_EN) begin
        data_q <= bus.LCD_DATA;
        rs_q   <= bus.LCD_RS;
        rw_q   <= bus.LCD_RW;
      end
      commit_q   <= fall & width_ok;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      long_q     <= long_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      disp_q     <= disp_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      perr_q     <= perr_d;
      if (clr_all) begin
        for (int i = 0; i < 32; i++) cells_q[i] <= 8'h20;
      end else if (wr_en) begin
        cells_q[cell_idx] <= data_q;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_now;
  assign disp_on      = disp_q;
  assign proto_err    = perr_q;
  assign char_out     = cells_q[char_idx];

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: directed scenarios plus random transfers
// against a position-based LCD model; read responses are checked by a scoreboard monitor.
module tb_lcd_responder;
  localparam int unsigned BusyCycles  = 40;
  localparam int unsigned ClearCycles = 1600;
  localparam int unsigned MinEnHigh   = 10;

  logic       clk2 = 1'b0;
  logic       rst  = 1'b0;
  logic       disp_on, proto_err, timing_err;
  logic [4:0] char_idx = '0;
  logic [7:0] char_out;

  lcd_responder_if bus ();

  lcd_responder #(
    .BUSY_CYCLES (BusyCycles),
    .CLEAR_CYCLES(ClearCycles),
    .MIN_EN_HIGH (MinEnHigh)
  ) dut (
    .clk2      (clk2),
    .rst       (rst),
    .bus       (bus),
    .disp_on   (disp_on),
    .char_idx  (char_idx),
    .char_out  (char_out),
    .proto_err (proto_err),
    .timing_err(timing_err)
  );

  always #5 clk2 = ~clk2;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Reference model: display as 32 positions, AC as a line/column address.
  logic [7:0] m_cells[32];
  int         m_ac;
  bit         m_id, m_disp, m_perr, m_terr;

  function automatic int pos_of(int ac);
    return ((ac >= 64) ? 16 : 0) + (ac % 16);
  endfunction

  function automatic int ac_of(int pos);
    return (pos / 16) * 64 + (pos % 16);
  endfunction

  function automatic bit legal(int ac);
    return (ac < 16) || (ac >= 64 && ac < 80);
  endfunction

  function automatic bit accepted(int high);
`ifdef LCD_RESP_TIMING_CHECK_EN
    return high >= MinEnHigh;
`else
    return high >= 0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_ac = 0; m_id = 1; m_disp = 0; m_perr = 0; m_terr = 0;
  endtask

  task automatic model_step();
    m_ac = ac_of((pos_of(m_ac) + (m_id ? 1 : 31)) % 32);
  endtask

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expected response.
  always @(negedge clk2) begin
    if (bus.rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: unexpected pulse got 0x%0h, expected none", bus.rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got 0x%0h, expected 0x%0h", bus.rd_data, e);
        end
      end
    end
  end

  task automatic xfer(bit rs, bit rw, logic [7:0] d, int high);
    @(posedge clk2); #1;
    bus.LCD_DATA = d; bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_EN = 1'b1;
    repeat (high) @(posedge clk2);
    #1 bus.LCD_EN = 1'b0;
    repeat (2) @(posedge clk2);
    #1;
  endtask

  task automatic wait_idle(string name, int exp_cycles);
    int n = 0;
    forever begin
      @(negedge clk2);
      if (!bus.busy) break;
      n++;
      if (n > int'(ClearCycles) + 100) begin
        $display("FAIL %s: busy never dropped", name);
        break;
      end
    end
    check(name, n, exp_cycles);
  endtask

  task automatic op_instr(logic [7:0] d, int high);
    int busy_len = 1 + int'(BusyCycles);
    if (!accepted(high)) begin
      m_terr = 1; busy_len = 0;
    end else if (d >= 128) m_ac = d - 128;
    else if (d >= 16) ;
    else if (d >= 8) m_disp = (d / 4) % 2;
    else if (d >= 4) m_id = (d / 2) % 2;
    else if (d >= 2) begin m_ac = 0; busy_len = 1 + int'(ClearCycles); end
    else if (d == 1) begin
      for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
      m_ac = 0; m_id = 1; busy_len = 1 + int'(ClearCycles);
    end
    xfer(1'b0, 1'b0, d, high);
    wait_idle("instr_busy_len", busy_len);
  endtask

  task automatic op_wdata(logic [7:0] d);
    int busy_len = 0;
    if (legal(m_ac)) begin
      m_cells[pos_of(m_ac)] = d; model_step(); busy_len = 1 + int'(BusyCycles);
    end else m_perr = 1;
    xfer(1'b1, 1'b0, d, $urandom_range(MinEnHigh, MinEnHigh + 4));
    wait_idle("wdata_busy_len", busy_len);
  endtask

  task automatic op_rdata();
    if (legal(m_ac)) begin
      exp_q.push_back(m_cells[pos_of(m_ac)]); model_step();
    end else m_perr = 1;
    xfer(1'b1, 1'b1, 8'h00, $urandom_range(MinEnHigh, MinEnHigh + 4));
    wait_idle("rdata_busy_len", 0);
  endtask

  task automatic op_status();
    exp_q.push_back(8'(m_ac));
    xfer(1'b0, 1'b1, 8'h00, MinEnHigh + 2);
    wait_idle("status_busy_len", 0);
  endtask

  task automatic check_flags();
    check("disp_on", int'(disp_on), int'(m_disp));
    check("proto_err", int'(proto_err), int'(m_perr));
    check("timing_err", int'(timing_err), int'(m_terr));
  endtask

  task automatic check_cell(int idx);
    @(negedge clk2);
    char_idx = 5'(idx);
    #1 check($sformatf("char_out[%0d]", idx), int'(char_out), int'(m_cells[idx]));
  endtask

  task automatic check_all_cells();
    for (int i = 0; i < 32; i++) check_cell(i);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.LCD_DATA = '0; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_EN = 1'b0;
    model_reset();
    repeat (3) @(posedge clk2);
    #1;
    check("reset busy", int'(bus.busy), 0);
    check("reset rd_valid", int'(bus.rd_valid), 0);
    check("reset rd_data", int'(bus.rd_data), 0);
    check_flags();
    check_cell(0);
    check_cell(31);
    @(negedge clk2) rst = 1'b1;

    // Power-up initialisation with long EN pulses.
    op_instr(8'h38, 98);
    op_instr(8'h0C, 98);
    op_instr(8'h06, 98);
    check_flags();
    op_status();

    // Second line writes.
    op_instr(8'hC0, 12);
    op_wdata(8'h44);
    op_wdata(8'h45);
    check_cell(16);
    check_cell(17);
    op_status();

    // Wrap from end of line 2 to start of line 1, and backwards.
    op_instr(8'hCF, 12);
    op_wdata(8'h41);
    check_cell(31);
    op_status();
    op_instr(8'h04, 12);
    op_wdata(8'h5A);
    check_cell(0);
    op_status();
    op_instr(8'h06, 12);

    // Random traffic.
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 7) op_wdata(8'($urandom_range(8'h21, 8'h7E)));
      else if (r < 10) op_instr(8'h80 | 8'($urandom_range(0, 127)), 12);
      else if (r == 10) op_instr(8'h04 | 8'($urandom_range(0, 3)), 12);
      else if (r < 14) op_rdata();
      else if (r < 16) op_status();
      else if (r == 16) op_instr(8'h08 | 8'($urandom_range(0, 7)), 12);
      else if (r == 17) op_instr(8'h40 | 8'($urandom_range(0, 63)), 12);
      else if (r == 18) op_instr(8'h14, 12);
      else op_instr(8'h02, 12);
      check_flags();
      check_cell($urandom_range(0, 31));
    end
    check_all_cells();

    // Short EN pulse.
    op_instr(8'h85, 12);
    op_instr(8'h80, 3);
    check_flags();
    op_status();

    // Write during clear busy time is dropped; status read still answers.
    op_instr(8'h06, 12);
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_ac = 0; m_id = 1;
    xfer(1'b0, 1'b0, 8'h01, 12);
    fork
      wait_idle("clear_busy_len", 1 + int'(ClearCycles));
      begin
        repeat (5) @(posedge clk2);
        m_perr = 1;
        xfer(1'b1, 1'b0, 8'h77, 12);
        exp_q.push_back(8'h80);
        xfer(1'b0, 1'b1, 8'h00, 12);
      end
    join
    check_flags();
    check_all_cells();
    op_status();

    // Reset during busy abandons the command.
    xfer(1'b0, 1'b0, 8'h0C, 12);
    repeat (5) @(posedge clk2);
    check("disp_on before reset", int'(disp_on), 1);
    @(negedge clk2) rst = 1'b0;
    #1;
    model_reset();
    check("busy in reset", int'(bus.busy), 0);
    check_flags();
    repeat (3) @(posedge clk2);
    @(negedge clk2) rst = 1'b1;
    op_instr(8'h0C, 12);
    m_disp = 1;
    check_flags();
    op_status();
    check_cell(5);

    repeat (4) @(posedge clk2);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
